mem_bank_write: RTL and testbench

- Write side of the 64 x 20-bit memory bank; owns the storage array.
- Exposes the whole array as a flat bus to the combinational bank read module, which selects a word by its 6-bit address.
- Accepts single-word writes via a valid/ack handshake.
- Provides a hardware fill sequencer that loads an incrementing pattern into every word, replacing per-word initialisation in benches.

---
 rtl/mem_bank_write.sv | 95 +++++++++
 tb/tb_mem_bank_write.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_write.sv
// Write side of the 64 x 20-bit memory bank: owns the storage, takes single-word writes and runs an incrementing-pattern fill.
// Define MEM_WP0_EN to hardwire word 0 to zero and add the wr_err port.
module mem_bank_write #(
  parameter int WORDS = 64,
  parameter int WIDTH = 20,
  parameter int AW    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   fill_start,
  input  logic [WIDTH-1:0]       fill_base,
  output logic [WORDS*WIDTH-1:0] bank_flat,
  output logic                   wr_ack,
  output logic                   busy,
  output logic                   fill_done
`ifdef MEM_WP0_EN
  ,
  output logic                   wr_err
`endif
);

  // Handshake: a write request (wr_en) is taken only in IDLE with fill_start low;
  // acceptance is confirmed by a one-cycle wr_ack the cycle after the sampling edge.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] base_q;
  logic             wr_req;
  logic             wr_zero;
  logic             wr_take;
  logic             fill_wr;

`ifdef MEM_WP0_EN
  assign wr_zero = (wr_addr == '0);
  assign fill_wr = (cnt != '0);
`else
  assign wr_zero = 1'b0;
  assign fill_wr = 1'b1;
`endif

  // Fill has priority over a same-cycle single write.
  assign wr_req  = (state == S_IDLE) && wr_en && !fill_start;
  assign wr_take = wr_req && !wr_zero;

  assign busy      = (state == S_FILL);
  assign fill_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_flat <= '0;
      state     <= S_IDLE;
      cnt       <= '0;
      base_q    <= '0;
      wr_ack    <= 1'b0;
`ifdef MEM_WP0_EN
      wr_err    <= 1'b0;
`endif
    end else begin
      wr_ack <= wr_take;
`ifdef MEM_WP0_EN
      wr_err <= wr_req && wr_zero;
`endif
      case (state)
        S_IDLE: begin
          if (fill_start) begin
            base_q <= fill_base;
            cnt    <= '0;
            state  <= S_FILL;
          end else if (wr_take) begin
            bank_flat[wr_addr*WIDTH +: WIDTH] <= wr_data;
          end
        end
        S_FILL: begin
          // Pattern sum is truncated to WIDTH bits, so the carry out is dropped.
          if (fill_wr) begin
            bank_flat[cnt*WIDTH +: WIDTH] <= base_q + WIDTH'(cnt);
          end
          cnt <= cnt + 1'b1;
          if (cnt == AW'(WORDS - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bank_write.sv
// Bench for mem_bank_write: directed steps plus random writes/fills against an array model of the bank.
module tb_mem_bank_write;
  localparam int WORDS = 64;
  localparam int WIDTH = 20;
  localparam int AW    = 6;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   fill_start;
  logic [WIDTH-1:0]       fill_base;
  logic [WORDS*WIDTH-1:0] bank_flat;
  logic                   wr_ack;
  logic                   busy;
  logic                   fill_done;
`ifdef MEM_WP0_EN
  logic                   wr_err;
  localparam bit WP0 = 1'b1;
`else
  localparam bit WP0 = 1'b0;
`endif

  logic [WIDTH-1:0] model_mem [WORDS];
  int checks = 0;
  int errors = 0;

  mem_bank_write dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fill_start (fill_start),
    .fill_base  (fill_base),
`ifdef MEM_WP0_EN
    .wr_err     (wr_err),
`endif
    .bank_flat  (bank_flat),
    .wr_ack     (wr_ack),
    .busy       (busy),
    .fill_done  (fill_done)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] rd(input logic [WORDS*WIDTH-1:0] f, input int r);
    return f[r*WIDTH +: WIDTH];
  endfunction

  function automatic logic [WORDS*WIDTH-1:0] model_flat();
    logic [WORDS*WIDTH-1:0] f;
    for (int i = 0; i < WORDS; i++) f[i*WIDTH +: WIDTH] = model_mem[i];
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bank(input string tag);
    logic [WORDS*WIDTH-1:0] exp;
    int bad;
    exp = model_flat();
    bad = -1;
    checks++;
    assert (bank_flat === exp) else begin
      errors++;
      for (int i = WORDS - 1; i >= 0; i--)
        if (rd(bank_flat, i) !== model_mem[i]) bad = i;
      $error("FAIL %s word %0d observed=%0h expected=%0h", tag, bad,
             rd(bank_flat, (bad < 0) ? 0 : bad), model_mem[(bad < 0) ? 0 : bad]);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
  endtask

  // Fill rule: word i becomes base + i modulo 2**WIDTH; word 0 untouched when hardwired.
  task automatic model_fill(input logic [WIDTH-1:0] base);
    for (int i = 0; i < WORDS; i++) begin
      logic [31:0] sum;
      sum = 32'(base) + 32'(i);
      if (!(WP0 && i == 0)) model_mem[i] = sum[WIDTH-1:0];
    end
  endtask

  // driver: one single-word write, checked the cycle after its sampling edge
  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    bit ok;
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
    ok = !(WP0 && a == '0);
    if (ok) model_mem[a] = d;
    check("wr_ack", 32'(wr_ack), 32'(ok));
`ifdef MEM_WP0_EN
    check("wr_err", 32'(wr_err), 32'(!ok));
`endif
    check_bank("bank_after_write");
  endtask

  // driver: complete fill with optional same-cycle write collision and random noise while busy
  task automatic run_fill(input logic [WIDTH-1:0] base, input bit collide);
    int n;
    int acks;
    fill_start = 1'b1;
    fill_base  = base;
    if (collide) begin
      wr_en   = 1'b1;
      wr_addr = 6'd5;
      wr_data = 20'hABCDE;
    end
    step();
    fill_start = 1'b0;
    wr_en      = 1'b0;
    check("start_no_ack", 32'(wr_ack), 32'd0);
    n = 0;
    acks = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      wr_en      = 1'($urandom_range(0, 1));
      fill_start = 1'($urandom_range(0, 1));
      wr_addr    = AW'($urandom);
      wr_data    = WIDTH'($urandom);
      fill_base  = WIDTH'($urandom);
      step();
      if (wr_ack !== 1'b0) acks++;
    end
    wr_en      = 1'b0;
    fill_start = 1'b0;
    check("busy_cycles", 32'(n), 32'd64);
    check("ack_during_fill", 32'(acks), 32'd0);
    check("fill_done_pulse", 32'(fill_done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    model_fill(base);
    check_bank("bank_after_fill");
    step();
    check("fill_done_one_cycle", 32'(fill_done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] b;
    int seen_done;
    rst = 1'b1; wr_en = 1'b1; wr_addr = 6'd3; wr_data = 20'h5;
    fill_start = 1'b0; fill_base = '0;
    model_clear();

    // reset wins over a concurrent write request
    repeat (3) step();
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fill_done", 32'(fill_done), 32'd0);
    check_bank("rst_bank");
    wr_en = 1'b0;
    rst = 1'b0;
    step();
    check("idle_rd63", 32'(rd(bank_flat, 63)), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // back-to-back single writes
    do_write(6'd1, 20'h00001);
    do_write(6'd32, 20'h00020);
    check("rd1", 32'(rd(bank_flat, 1)), 32'h1);
    check("rd32", 32'(rd(bank_flat, 32)), 32'h20);
    step();
    check("ack_single_pulse", 32'(wr_ack), 32'd0);
    for (int i = 0; i < 20; i++) do_write(AW'($urandom), WIDTH'($urandom));

    // fill from base 0
    run_fill(20'h00000, 1'b0);
    check("fill_rd1", 32'(rd(bank_flat, 1)), 32'd1);
    check("fill_rd32", 32'(rd(bank_flat, 32)), 32'd32);
    check("fill_rd48", 32'(rd(bank_flat, 48)), 32'd48);
    check("fill_rd63", 32'(rd(bank_flat, 63)), 32'd63);
    do_write(6'd7, 20'h77777);

    // wrap of the pattern sum
    run_fill(20'hFFFC0, 1'b0);
    check("wrap_rd63", 32'(rd(bank_flat, 63)), 32'hFFFFF);
    run_fill(20'hFFFF0, 1'b0);
    check("wrap_rd16", 32'(rd(bank_flat, 16)), 32'h00000);
    check("wrap_rd63b", 32'(rd(bank_flat, 63)), 32'h0002F);

    // fill wins over a same-cycle write
    b = WIDTH'($urandom);
    run_fill(b, 1'b1);
    check("collide_rd5", 32'(rd(bank_flat, 5)), 32'(WIDTH'(b + 20'd5)));

    // reset during cycle 30 of a fill
    fill_start = 1'b1;
    fill_base  = 20'h12345;
    step();
    fill_start = 1'b0;
    repeat (29) step();
    check("mid_fill_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    check_bank("abort_bank");
    check("abort_busy", 32'(busy), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (fill_done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);

    // address 0 write (blocked when word 0 is hardwired)
    do_write(6'd0, 20'h12345);
    check("rd0", 32'(rd(bank_flat, 0)), WP0 ? 32'd0 : 32'h12345);
    step();
`ifdef MEM_WP0_EN
    check("wr_err_pulse", 32'(wr_err), 32'd0);
`endif
    check("ack_idle", 32'(wr_ack), 32'd0);

    // random mix of fills and writes
    for (int k = 0; k < 4; k++) begin
      run_fill(WIDTH'($urandom), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 8; i++) do_write(AW'($urandom), WIDTH'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
